// File: rtl/pm_mux_pipe.sv
// pm_mux_pipe: pipelined CHANNELS:1 program-memory word selector feeding a
// 2-entry output FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk       - single clock, all state changes on its rising edge
//   reset     - synchronous active-high reset, highest priority
//   d         - flattened channels, channel k = d[k*WIDTH +: WIDTH]
//   s         - channel select, sampled when a word is accepted
//   in_valid  - source presents d/s
//   in_ready  - block can accept (occupancy below 2, registered only)
//   y         - word at buffer head (last popped word or 0 while empty)
//   y_valid   - buffer non-empty
//   y_ready   - consumer accepts y
//   sel_err   - sticky out-of-range select flag
//   err_clr   - clears sel_err (a simultaneous new error wins)
//   count     - buffer occupancy 0..2
module pm_mux_pipe #(
  parameter int WIDTH      = 4,
  parameter int CHANNELS   = 4,
  parameter int SEL_W      = 2,
  parameter bit LATCH_LAST = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          s,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic                      sel_err,
  input  logic                      err_clr,
  output logic [1:0]                count
);

  // One-hot channel decode. A select with no matching channel leaves all
  // hits low, which both zeroes the selected word and flags the error.
  logic [CHANNELS-1:0] hit;
  logic [WIDTH-1:0]    masked [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign hit[gi]    = (s == SEL_W'(gi));
      assign masked[gi] = hit[gi] ? d[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  logic [WIDTH-1:0] sel_word;
  logic             in_range;

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_word = sel_word | masked[k];
    end
  end

  assign in_range = |hit;

  // Storage: entry0 is the head, entry1 the skid slot.
  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [1:0]       count_q, count_d;
  logic             err_q, err_d;

  logic push;
  logic pop;

  assign in_ready = (count_q < 2'd2);
  assign y_valid  = (count_q != 2'd0);
  assign push     = in_valid && in_ready;
  assign pop      = y_valid && y_ready;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    last_d  = pop ? e0_q : last_q;

    case (count_q)
      2'd0: begin
        if (push) begin
          e0_d    = sel_word;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // Head leaves and the new word takes its place with no bubble.
          e0_d = sel_word;
        end else if (push) begin
          e1_d    = sel_word;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          e0_d    = e1_q;
          count_d = 2'd1;
        end
      end
    endcase

    // Set takes priority over clear.
    if (push && !in_range) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e0_q    <= '0;
      e1_q    <= '0;
      last_q  <= '0;
      count_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      last_q  <= last_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Output depends only on registered state.
  always_comb begin
    if (y_valid) begin
      y = e0_q;
    end else if (LATCH_LAST) begin
      y = last_q;
    end else begin
      y = '0;
    end
  end

  assign count   = count_q;
  assign sel_err = err_q;

endmodule

// File: tb/tb_pm_mux_pipe.sv
// Bench for pm_mux_pipe. Two instances share one stimulus stream:
//   A: WIDTH=4, CHANNELS=4, SEL_W=2, LATCH_LAST=1 (every select legal)
//   B: WIDTH=4, CHANNELS=3, SEL_W=2, LATCH_LAST=0 (s=3 is out of range)
// A queue-based reference model per instance tracks expected contents;
// a monitor on the falling edge compares every output and pops the
// expected queue on each output handshake.
module tb_pm_mux_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] d_in;
  logic [1:0]  s_in;
  logic        in_valid;
  logic        y_ready;
  logic        err_clr;

  logic       in_ready_a, y_valid_a, sel_err_a;
  logic [3:0] y_a;
  logic [1:0] count_a;
  logic       in_ready_b, y_valid_b, sel_err_b;
  logic [3:0] y_b;
  logic [1:0] count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pm_mux_pipe #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .LATCH_LAST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .d(d_in), .s(s_in), .in_valid(in_valid),
    .in_ready(in_ready_a), .y(y_a), .y_valid(y_valid_a), .y_ready(y_ready),
    .sel_err(sel_err_a), .err_clr(err_clr), .count(count_a)
  );

  pm_mux_pipe #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .LATCH_LAST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .d(d_in[11:0]), .s(s_in), .in_valid(in_valid),
    .in_ready(in_ready_b), .y(y_b), .y_valid(y_valid_b), .y_ready(y_ready),
    .sel_err(sel_err_b), .err_clr(err_clr), .count(count_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [3:0] last_a = 4'h0;
  bit         err_b = 1'b0;
  bit         started = 1'b0;

  always @(negedge clk) begin
    logic       acc, take;
    logic [3:0] w, popped;
    if (started) begin
      chk("count_a",    32'(count_a),    32'(qa.size()));
      chk("in_ready_a", 32'(in_ready_a), 32'(qa.size() < 2));
      chk("y_valid_a",  32'(y_valid_a),  32'(qa.size() > 0));
      chk("y_a",        32'(y_a),        32'(qa.size() > 0 ? qa[0] : last_a));
      chk("sel_err_a",  32'(sel_err_a),  32'(0));
      chk("count_b",    32'(count_b),    32'(qb.size()));
      chk("in_ready_b", 32'(in_ready_b), 32'(qb.size() < 2));
      chk("y_valid_b",  32'(y_valid_b),  32'(qb.size() > 0));
      chk("y_b",        32'(y_b),        32'(qb.size() > 0 ? qb[0] : 4'h0));
      chk("sel_err_b",  32'(sel_err_b),  32'(err_b));
    end
    if (reset) begin
      qa.delete();
      qb.delete();
      last_a  = 4'h0;
      err_b   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      acc  = in_valid && (qa.size() < 2);
      take = y_ready && (qa.size() > 0);
      if (take) begin
        popped = qa.pop_front();
        last_a = popped;
        void'(qb.pop_front());
        $display("pop  t=%0t y_a=%h y_b=%h", $time, y_a, y_b);
      end
      if (acc) begin
        w = 4'((d_in >> (4 * int'(s_in))) & 16'hF);
        qa.push_back(w);
        qb.push_back((int'(s_in) < 3) ? w : 4'h0);
      end
      if (acc && int'(s_in) >= 3) err_b = 1'b1;
      else if (err_clr)           err_b = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v, input logic [1:0] sel, input logic [15:0] dv,
                     input logic yr, input logic clr, input logic rst);
    in_valid = v;
    s_in     = sel;
    d_in     = dv;
    y_ready  = yr;
    err_clr  = clr;
    reset    = rst;
    @(posedge clk);
    #2;
  endtask

  initial begin
    in_valid = 0; s_in = 0; d_in = 0; y_ready = 0; err_clr = 0; reset = 1;
    @(posedge clk); #2;
    cyc(0, 0, 16'h0, 0, 0, 1);

    // Reset mid-stream with two words buffered.
    cyc(1, 0, 16'h0003, 0, 0, 0);
    cyc(1, 0, 16'h0005, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 0, 1);
    cyc(0, 0, 16'h0000, 0, 0, 0);

    // Basic select, continuous draining.
    for (int i = 0; i < 4; i++) cyc(1, 2'(i), 16'hDCBA, 1, 0, 0);
    cyc(0, 0, 16'hDCBA, 1, 0, 0);

    // Backpressure: fill, ignored third push, then drain.
    cyc(1, 1, 16'hDCBA, 0, 0, 0);
    cyc(1, 2, 16'hDCBA, 0, 0, 0);
    cyc(1, 0, 16'hDCBA, 0, 0, 0);
    cyc(0, 0, 16'hDCBA, 1, 0, 0);
    cyc(0, 0, 16'hDCBA, 1, 0, 0);
    cyc(0, 0, 16'hDCBA, 1, 0, 0);

    // Simultaneous push/pop at count=1.
    cyc(1, 0, 16'hDCBA, 0, 0, 0);
    cyc(1, 3, 16'hDCBA, 1, 0, 0);
    cyc(0, 0, 16'hDCBA, 0, 0, 0);
    cyc(0, 0, 16'hDCBA, 1, 0, 0);

    // Out-of-range select on instance B, sticky flag, clear, set-wins.
    cyc(1, 3, 16'hDCBA, 1, 0, 0);
    cyc(1, 0, 16'hDCBA, 1, 0, 0);
    cyc(1, 1, 16'hDCBA, 1, 0, 0);
    cyc(0, 0, 16'hDCBA, 1, 1, 0);
    cyc(0, 0, 16'hDCBA, 1, 0, 0);
    cyc(1, 3, 16'hDCBA, 1, 1, 0);
    cyc(0, 0, 16'hDCBA, 1, 1, 0);
    cyc(0, 0, 16'hDCBA, 1, 0, 0);

    // Empty hold: last popped 4'hC stays on A, B drives 0.
    cyc(1, 2, 16'hDCBA, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    cyc(0, 0, 16'h0000, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
          $urandom_range(0, 199) == 0);
    end
    cyc(0, 0, 16'h0, 1, 0, 0);
    cyc(0, 0, 16'h0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
